// File: rtl/tie_control_arbiter.sv
// Round-robin sharing of the core's TIE_control word between two requesters; each accepted word is held for HOLD_CYCLES.
// Optional macro TIE_CONTROL_ARB_ACK_EN: leave HOLD early once TIE_status echoes TIE_control, flag sticky ack_timeout otherwise.
module tie_control_arbiter #(
    parameter int W           = 50,
    parameter int HOLD_CYCLES = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req0_valid_i,
    input  logic [W-1:0] req0_data_i,
    output logic         req0_ready_o,
    input  logic         req1_valid_i,
    input  logic [W-1:0] req1_data_i,
    output logic         req1_ready_o,
    input  logic [W-1:0] TIE_status_i,
    output logic [W-1:0] TIE_control_o,
    output logic         grant_id_o,
    output logic         busy_o,
    output logic         ack_timeout_o
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [7:0] CNT_INIT = 8'(HOLD_CYCLES - 1);

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         ptr_q, ptr_d;
    logic [W-1:0] ctrl_q, ctrl_d;
    logic         gid_q, gid_d;
    logic         to_q, to_d;
    logic         gnt;
    logic         xfer;
    logic         ack_hit;

`ifdef TIE_CONTROL_ARB_ACK_EN
    localparam logic ACK_EN = 1'b1;
    assign ack_hit = (TIE_status_i == ctrl_q);
`else
    localparam logic ACK_EN = 1'b0;
    logic unused_status;
    assign unused_status = ^TIE_status_i;
    assign ack_hit       = 1'b0;
`endif

    // On contention the requester that was not served last wins.
    always_comb begin
        if (req0_valid_i && req1_valid_i) gnt = ~ptr_q;
        else                              gnt = ~req0_valid_i;
    end

    assign xfer          = (state_q == IDLE) && !rst_i && (req0_valid_i || req1_valid_i);
    assign req0_ready_o  = xfer && !gnt;
    assign req1_ready_o  = xfer && gnt;
    assign TIE_control_o = ctrl_q;
    assign grant_id_o    = gid_q;
    assign busy_o        = (state_q == HOLD);
    assign ack_timeout_o = to_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ctrl_d  = ctrl_q;
        gid_d   = gid_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    ctrl_d  = gnt ? req1_data_i : req0_data_i;
                    gid_d   = gnt;
                    ptr_d   = gnt;
                    cnt_d   = CNT_INIT;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                cnt_d = cnt_q - 8'd1;
                // An echo on the final count still counts as an acknowledge.
                if (ack_hit) begin
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    to_d    = to_q | ACK_EN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= 1'b1;
            ctrl_q  <= '0;
            gid_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ctrl_q  <= ctrl_d;
            gid_q   <= gid_d;
            to_q    <= to_d;
        end
    end
endmodule

// File: tb/tb_tie_control_arbiter.sv
// Self-checking bench for tie_control_arbiter: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_tie_control_arbiter;
    localparam int W    = 50;
    localparam int HOLD = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req0_valid_i, req1_valid_i;
    logic [W-1:0] req0_data_i, req1_data_i;
    logic         req0_ready_o, req1_ready_o;
    logic [W-1:0] TIE_status_i;
    logic [W-1:0] TIE_control_o;
    logic         grant_id_o, busy_o, ack_timeout_o;

    int checks   = 0;
    int failures = 0;

    tie_control_arbiter #(.W(W), .HOLD_CYCLES(HOLD)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .TIE_status_i (TIE_status_i),
        .TIE_control_o(TIE_control_o),
        .grant_id_o   (grant_id_o),
        .busy_o       (busy_o),
        .ack_timeout_o(ack_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic do_reset();
        rst_i = 1'b1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_data_i = '0; req1_data_i = '0; TIE_status_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        req0_data_i = W'(50'h11); req1_data_i = W'(50'h22); TIE_status_i = '0;
        @(negedge clk_i);
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b00) begin
            failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready_o, req1_ready_o});
        end
        checks++;
        if ({TIE_control_o, grant_id_o, busy_o, ack_timeout_o} !== '0) begin
            failures++; $display("FAIL reset_outputs ctrl=%h gid=%b busy=%b to=%b exp all 0",
                                 TIE_control_o, grant_id_o, busy_o, ack_timeout_o);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            failures++; $display("FAIL first_contention got=%b exp=10", {req0_ready_o, req1_ready_o});
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    endtask

    task automatic test_single();
        int n = 0;
        do_reset();
        req0_valid_i = 1'b1; req0_data_i = W'(50'h0_0000_DEAD_BEEF);
        #1;
        checks++;
        if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin
            failures++; $display("FAIL single_ready got=%b%b exp=10", req0_ready_o, req1_ready_o);
        end
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0;
        checks++;
        if (TIE_control_o !== W'(50'h0_0000_DEAD_BEEF) || grant_id_o !== 1'b0) begin
            failures++; $display("FAIL single_ctrl got=%h gid=%b exp=0000deadbeef gid=0", TIE_control_o, grant_id_o);
        end
        for (int i = 0; i < 10; i++) begin
            if (busy_o) n++;
            @(posedge clk_i); #1;
        end
        checks++;
        if (n != HOLD) begin
            failures++; $display("FAIL single_busy_len got=%0d exp=%0d", n, HOLD);
        end
        checks++;
        if (TIE_control_o !== W'(50'h0_0000_DEAD_BEEF)) begin
            failures++; $display("FAIL single_ctrl_held got=%h exp=0000deadbeef", TIE_control_o);
        end
    endtask

    task automatic test_alternate();
        logic [W-1:0] prev = '0;
        logic [W-1:0] vals[$];
        logic         gids[$];
        int           at[$];
        do_reset();
        req0_valid_i = 1'b1; req0_data_i = W'(1);
        req1_valid_i = 1'b1; req1_data_i = W'(2);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk_i); #1;
            if (TIE_control_o !== prev) begin
                vals.push_back(TIE_control_o); gids.push_back(grant_id_o); at.push_back(c);
                prev = TIE_control_o;
            end
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        checks++;
        if (vals.size() < 4) begin
            failures++; $display("FAIL alt_count got=%0d exp>=4", vals.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (vals[i] !== W'((i % 2) + 1) || gids[i] !== 1'((i % 2))) begin
                    failures++; $display("FAIL alt_seq[%0d] got=%h gid=%b exp=%0d gid=%0d", i, vals[i], gids[i], (i % 2) + 1, i % 2);
                end
                if (i > 0) begin
                    checks++;
                    if (at[i] - at[i-1] != HOLD + 1) begin
                        failures++; $display("FAIL alt_spacing[%0d] got=%0d exp=%0d", i, at[i] - at[i-1], HOLD + 1);
                    end
                end
            end
        end
    endtask

    task automatic test_hold_block();
        int n = 0;
        do_reset();
        req0_valid_i = 1'b1; req0_data_i = W'(50'h3_AAAA_5555_0001);
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b1; req1_data_i = W'(50'h1_2345_6789_ABCD);
        while (busy_o && n < 20) begin
            checks++;
            if (req1_ready_o !== 1'b0) begin
                failures++; $display("FAIL hold_ready1 cycle=%0d got=%b exp=0", n, req1_ready_o);
            end
            @(posedge clk_i); #1;
            n++;
        end
        checks++;
        if (n != HOLD) begin
            failures++; $display("FAIL hold_len got=%0d exp=%0d", n, HOLD);
        end
        checks++;
        if (req1_ready_o !== 1'b1) begin
            failures++; $display("FAIL hold_exit_ready1 got=%b exp=1", req1_ready_o);
        end
        @(posedge clk_i); #1;
        req1_valid_i = 1'b0;
        checks++;
        if (TIE_control_o !== W'(50'h1_2345_6789_ABCD) || grant_id_o !== 1'b1) begin
            failures++; $display("FAIL hold_req1_ctrl got=%h gid=%b exp=123456789abcd gid=1", TIE_control_o, grant_id_o);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req0_valid_i = 1'b1; req0_data_i = W'(50'h0_0000_0000_C0DE);
        @(posedge clk_i); #1;
        req0_data_i = W'(50'h2_0000_0000_D00D);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        checks++;
        if (TIE_control_o !== '0 || busy_o !== 1'b0 || grant_id_o !== 1'b0
            || req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
            failures++; $display("FAIL midhold_reset ctrl=%h busy=%b gid=%b rdy=%b%b exp all 0",
                                 TIE_control_o, busy_o, grant_id_o, req0_ready_o, req1_ready_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if (req0_ready_o !== 1'b1) begin
            failures++; $display("FAIL midhold_regrant got=%b exp=1", req0_ready_o);
        end
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0;
        checks++;
        if (TIE_control_o !== W'(50'h2_0000_0000_D00D)) begin
            failures++; $display("FAIL midhold_ctrl got=%h exp=20000_0000d00d", TIE_control_o);
        end
    endtask

`ifdef TIE_CONTROL_ARB_ACK_EN
    task automatic test_ack();
        int n = 0;
        do_reset();
        req0_valid_i = 1'b1; req0_data_i = W'(50'h0_0000_0000_0ACE);
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0;
        TIE_status_i = W'(50'h0_0000_0000_0ACE);
        for (int i = 0; i < 8; i++) begin
            if (busy_o) n++;
            @(posedge clk_i); #1;
        end
        checks++;
        if (n != 1 || ack_timeout_o !== 1'b0) begin
            failures++; $display("FAIL ack_early busy=%0d to=%b exp busy=1 to=0", n, ack_timeout_o);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        req0_valid_i = 1'b1; req0_data_i = W'(50'h0_0000_0000_0BAD);
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (busy_o) n++;
            @(posedge clk_i); #1;
        end
        checks++;
        if (n != HOLD || ack_timeout_o !== 1'b1) begin
            failures++; $display("FAIL timeout busy=%0d to=%b exp busy=%0d to=1", n, ack_timeout_o, HOLD);
        end
        req1_valid_i = 1'b1; req1_data_i = W'(50'h0_0000_0000_0F00);
        TIE_status_i = W'(50'h0_0000_0000_0F00);
        @(posedge clk_i); #1;
        req1_valid_i = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy_o) n++;
            @(posedge clk_i); #1;
        end
        checks++;
        if (n != 1 || ack_timeout_o !== 1'b1) begin
            failures++; $display("FAIL timeout_sticky busy=%0d to=%b exp busy=1 to=1", n, ack_timeout_o);
        end
        do_reset();
        checks++;
        if (ack_timeout_o !== 1'b0) begin
            failures++; $display("FAIL timeout_clear got=%b exp=0", ack_timeout_o);
        end
    endtask
`endif

    // Reference model: remaining hold cycles, last-served index, current word.
    task automatic test_random();
        logic [W-1:0] d0 = '0, d1 = '0, m_ctrl = '0;
        bit           p0 = 0, p1 = 0, m_ptr = 1, m_gid = 0, m_to = 0;
        int           m_hold = 0;
        int           w;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_i);
            if (!p0 && $urandom_range(0, 2) == 0) begin p0 = 1; d0 = W'({$urandom, $urandom}); end
            if (!p1 && $urandom_range(0, 2) == 0) begin p1 = 1; d1 = W'({$urandom, $urandom}); end
            req0_valid_i = p0; req0_data_i = d0;
            req1_valid_i = p1; req1_data_i = d1;
            TIE_status_i = ($urandom_range(0, 3) == 0) ? m_ctrl : W'({$urandom, $urandom});
            #1;
            w = -1;
            if (m_hold == 0) begin
                if (p0 && p1) w = m_ptr ? 0 : 1;
                else if (p0)  w = 0;
                else if (p1)  w = 1;
            end
            checks++;
            if (req0_ready_o !== (w == 0) || req1_ready_o !== (w == 1)) begin
                failures++; $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", cyc, req0_ready_o, req1_ready_o, w == 0, w == 1);
            end
            checks++;
            if (busy_o !== (m_hold > 0) || TIE_control_o !== m_ctrl || grant_id_o !== m_gid || ack_timeout_o !== m_to) begin
                failures++; $display("FAIL rand_state cyc=%0d got busy=%b ctrl=%h gid=%b to=%b exp busy=%b ctrl=%h gid=%b to=%b",
                                     cyc, busy_o, TIE_control_o, grant_id_o, ack_timeout_o, m_hold > 0, m_ctrl, m_gid, m_to);
            end
            if (w >= 0) begin
                m_ctrl = (w == 0) ? d0 : d1;
                m_gid  = (w == 1);
                m_ptr  = (w == 1);
                m_hold = HOLD;
                if (w == 0) p0 = 0; else p1 = 0;
            end else if (m_hold > 0) begin
`ifdef TIE_CONTROL_ARB_ACK_EN
                if (TIE_status_i == m_ctrl) m_hold = 0;
                else begin
                    if (m_hold == 1) m_to = 1;
                    m_hold--;
                end
`else
                m_hold--;
`endif
            end
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_hold_block();
        test_reset_mid_hold();
`ifdef TIE_CONTROL_ARB_ACK_EN
        test_ack();
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tie_control_arbiter.md
# tie_control_arbiter

Shares the 50-bit TIE_control export port of the cosim Xtensa model between two independent requesters (e.g. a testbench command source and a status-loopback source). Each accepted request is registered onto TIE_control and held stable for a guaranteed window so the core can sample it, with round-robin fairness between requesters. Sits between the requester logic and the core-facing TIE_control/TIE_status pins in the Verilog cosim top.

## Interface
- W, 50, payload width; equals TIE_control/TIE_status width.
- HOLD_CYCLES, 4, minimum cycles TIE_control is held after an update; legal range 1..255.
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a payload.
- req0_data  input  W  requester 0 payload.
- req0_ready  output  1  requester 0 payload accepted this cycle.
- req1_valid  input  1  requester 1 has a payload.
- req1_data  input  W  requester 1 payload.
- req1_ready  output  1  requester 1 payload accepted this cycle.
- TIE_status  input  W  status word from the core.
- TIE_control  output  W  registered control word to the core.
- grant_id  output  1  requester that produced the current TIE_control.
- busy  output  1  high while in HOLD.
- ack_timeout  output  1  sticky: a hold ended by timeout instead of acknowledge.

## Operation
- FSM states: IDLE, HOLD. Reset state IDLE.
- IDLE: if any reqN_valid, grant one requester; its reqN_ready is high combinationally that cycle (ready only in IDLE, never while Reset is high); transfer = valid & ready.
- Arbitration: round-robin on a last-served pointer. Only one valid -> that one wins. Both valid -> the requester not equal to pointer wins. Pointer resets to 1, so requester 0 wins first contention.
- On transfer: TIE_control <= granted data, grant_id <= granted index, pointer <= granted index, hold counter <= HOLD_CYCLES-1, state -> HOLD.
- HOLD: counter decrements each cycle; at counter==0 state -> IDLE. No ready asserted; valid inputs are ignored and must be held by requesters (valid/data stable until ready).
- TIE_control changes only on a transfer edge; otherwise holds its value indefinitely.
- Reset mid-HOLD: immediate return to IDLE, all outputs to reset values; the in-flight word is dropped from TIE_control.
- Reset values: TIE_control=0, grant_id=0, busy=0, req0_ready=0, req1_ready=0, ack_timeout=0.

## Timing
- Transfer at edge k -> TIE_control valid after edge k (1-cycle latency from ready).
- busy high for exactly HOLD_CYCLES cycles after edge k (without macro).
- Earliest next ready: cycle after HOLD exit; back-to-back transfers spaced HOLD_CYCLES+1 cycles.
- Both requesters continuously valid: grants alternate 0,1,0,1...; each served once per 2*(HOLD_CYCLES+1) cycles.
- HOLD_CYCLES=1: one HOLD cycle, transfers every 2 cycles.

## Configuration
- Macro TIE_CONTROL_ARB_ACK_EN.
- Defined: HOLD also exits early on the first HOLD cycle where TIE_status == TIE_control (core echoes the word as acknowledge); sampled from the cycle after the transfer edge. If counter reaches 0 without match, exit anyway and set ack_timeout (sticky until Reset). Match and counter==0 in the same cycle counts as acknowledge (no timeout).
- Undefined: TIE_status is unused; HOLD is always exactly HOLD_CYCLES; ack_timeout tied 0.

## Test plan
- Reset then req0_valid=1, data=50'h0_0000_DEAD_BEEF, HOLD_CYCLES=4 -> req0_ready high 1 cycle, TIE_control=50'h0_0000_DEAD_BEEF next edge, grant_id=0, busy high 4 cycles, TIE_control unchanged until next transfer.
- Both valid continuously, data0=50'h1, data1=50'h2 -> TIE_control sequence 1,2,1,2 with changes exactly 5 cycles apart; grant_id alternates 0,1.
- req1 valid during HOLD of a req0 transfer -> req1_ready stays 0 until HOLD exit, then req1 granted on first IDLE cycle.
- Assert Reset 2 cycles into HOLD -> TIE_control=0, busy=0, readies 0 asynchronously; after release, pending req0 granted on first cycle.
- TIE_CONTROL_ARB_ACK_EN defined, TIE_status driven equal to TIE_control 1 cycle after transfer -> busy lasts 1 cycle, ack_timeout stays 0.
- TIE_CONTROL_ARB_ACK_EN defined, TIE_status never matches -> busy lasts 4 cycles, ack_timeout sets and remains 1 across later acknowledged transfers until Reset.
